// File: rtl/mbox_arbiter.sv
// Two-requester packet arbiter feeding the MAILBOX byte FIFO.
// Words are serialized LSB first; a packet is owned until its last byte or a stall timeout.
module mbox_arbiter #(
    parameter int WB_DW   = 32,
    parameter int WOU_DW  = 8,
    parameter int TO_W    = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [1:0]        req_i,
    input  logic [WB_DW-1:0]  word_i_0,
    input  logic [WB_DW-1:0]  word_i_1,
    input  logic [1:0]        last_i,
    output logic [1:0]        ack_o,
    output logic              mbox_wr_o,
    output logic [WOU_DW-1:0] mbox_do_o,
    input  logic              mbox_full_i,
    output logic [1:0]        gnt_o,
    output logic              pkt_done_o,
    output logic [1:0]        err_o,
    input  logic [1:0]        err_clr_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [WB_DW-1:0]  buf_q, buf_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [TO_W-1:0]   timer_q, timer_d;
    logic              owner_q, owner_d;
    logic              rr_last_q, rr_last_d;
    logic              lastf_q, lastf_d;
    logic [1:0]        err_q, err_d;
    logic              win;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        lastf_d    = lastf_q;
        err_d      = err_q & ~err_clr_i;
        win        = 1'b0;
        ack_o      = '0;
        mbox_wr_o  = 1'b0;
        pkt_done_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_i != 2'b00) begin
                    // On a tie the requester that did not own the previous packet wins
                    win       = (req_i == 2'b11) ? ~rr_last_q : req_i[1];
                    ack_o     = win ? 2'b10 : 2'b01;
                    buf_d     = win ? word_i_1 : word_i_0;
                    lastf_d   = last_i[win];
                    owner_d   = win;
                    cnt_d     = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!mbox_full_i) begin
                    mbox_wr_o = 1'b1;
                    buf_d     = buf_q >> WOU_DW;
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (lastf_q) begin
                            pkt_done_o = 1'b1;
                            rr_last_d  = owner_q;
                            state_d    = S_IDLE;
                        end else begin
                            timer_d = '0;
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (req_i[owner_q]) begin
                    ack_o   = owner_q ? 2'b10 : 2'b01;
                    buf_d   = owner_q ? word_i_1 : word_i_0;
                    lastf_d = last_i[owner_q];
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
                    // Set has priority over a same-cycle clear
                    err_d[owner_q] = 1'b1;
                    rr_last_d      = owner_q;
                    state_d        = S_IDLE;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            lastf_q   <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            lastf_q   <= lastf_d;
            err_q     <= err_d;
        end
    end

    assign mbox_do_o = buf_q[WOU_DW-1:0];
    assign gnt_o     = (state_q == S_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign err_o     = err_q;

endmodule
